// File: rtl/pc_sequencer_if.sv
// Control/target bundle for pc_sequencer.
//   master : instruction-decode side; drives the branch controls, immediate and register target,
//            and observes the PC and return-address-stack (RAS) status.
//   slave  : the sequencer itself.
// Signals:
//   stall, Branch, BranchNZ, ALUZero, Uncondbranch, RegBranch, Link, Return   (master -> slave)
//   SignExtImm, RegTarget                                                      (master -> slave)
//   CurrentPC, NextPC, LinkAddr, ras_empty, ras_full, ras_ovf                  (slave -> master)
interface pc_sequencer_if #(
  parameter int unsigned XLEN = 64
);
  logic            stall;
  logic            Branch;
  logic            BranchNZ;
  logic            ALUZero;
  logic            Uncondbranch;
  logic            RegBranch;
  logic            Link;
  logic            Return;
  logic [XLEN-1:0] SignExtImm;
  logic [XLEN-1:0] RegTarget;
  logic [XLEN-1:0] CurrentPC;
  logic [XLEN-1:0] NextPC;
  logic [XLEN-1:0] LinkAddr;
  logic            ras_empty;
  logic            ras_full;
  logic            ras_ovf;

  modport master (
    output stall, Branch, BranchNZ, ALUZero, Uncondbranch, RegBranch, Link, Return,
    output SignExtImm, RegTarget,
    input  CurrentPC, NextPC, LinkAddr, ras_empty, ras_full, ras_ovf
  );

  modport slave (
    input  stall, Branch, BranchNZ, ALUZero, Uncondbranch, RegBranch, Link, Return,
    input  SignExtImm, RegTarget,
    output CurrentPC, NextPC, LinkAddr, ras_empty, ras_full, ras_ovf
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with a circular return-address stack.
// Ports:
//   CLK     : clock, all state updates on the rising edge
//   resetl  : asynchronous active-low reset
//   bus     : pc_sequencer_if.slave (branch controls in, PC / RAS status out)
// NextPC priority: Return > RegBranch > Uncondbranch > taken conditional > PC+4.
// The RAS overwrites its oldest entry when pushed while full and records that in ras_ovf,
// which only reset clears.
module pc_sequencer #(
  parameter int unsigned     XLEN      = 64,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     RAS_DEPTH = 4,
  parameter int unsigned     IMM_SHIFT = 2
) (
  input logic          CLK,
  input logic          resetl,
  pc_sequencer_if.slave bus
);

  localparam int unsigned     PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned     CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(RAS_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [PtrW-1:0] ptr_q, ptr_d;   // next free slot; top lives at ptr_q - 1
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;

  logic [PtrW-1:0] top_idx;
  logic [XLEN-1:0] ras_top;
  logic [XLEN-1:0] link_addr;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] next_pc;
  logic            empty, full, cond_taken;
  logic            ras_we;
  logic [PtrW-1:0] ras_widx;

  assign top_idx    = ptr_q - PtrW'(1);
  assign ras_top    = ras_q[top_idx];
  assign empty      = (cnt_q == '0);
  assign full       = (cnt_q == CntFull);
  assign link_addr  = pc_q + XLEN'(4);
  assign br_target  = pc_q + (bus.SignExtImm << IMM_SHIFT);
  assign cond_taken = bus.Branch && (bus.BranchNZ ? !bus.ALUZero : bus.ALUZero);

  always_comb begin
    if (bus.Return) begin
      next_pc = empty ? bus.RegTarget : ras_top;
    end else if (bus.RegBranch) begin
      next_pc = {bus.RegTarget[XLEN-1:2], 2'b00};
    end else if (bus.Uncondbranch || cond_taken) begin
      next_pc = br_target;
    end else begin
      next_pc = link_addr;
    end
  end

  always_comb begin
    pc_d     = pc_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    ras_we   = 1'b0;
    ras_widx = ptr_q;
    if (!bus.stall) begin
      pc_d = next_pc;
      if (bus.Link && bus.Return && !empty) begin
        // Pop and push in one cycle: replace the top in place, occupancy unchanged.
        ras_we   = 1'b1;
        ras_widx = top_idx;
      end else if (bus.Link) begin
        // When full, ptr_q already points at the oldest entry, so this overwrites it.
        ras_we = 1'b1;
        ptr_d  = ptr_q + PtrW'(1);
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end else if (bus.Return && !empty) begin
        ptr_d = ptr_q - PtrW'(1);
        cnt_d = cnt_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      pc_q  <= RESET_PC;
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Entry storage carries no reset; contents are never selected while the stack is empty.
  always_ff @(posedge CLK) begin
    if (ras_we) begin
      ras_q[ras_widx] <= link_addr;
    end
  end

  assign bus.CurrentPC = pc_q;
  assign bus.NextPC    = next_pc;
  assign bus.LinkAddr  = link_addr;
  assign bus.ras_empty = empty;
  assign bus.ras_full  = full;
  assign bus.ras_ovf   = ovf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (XLEN=64, RESET_PC=0, RAS_DEPTH=4, IMM_SHIFT=2).
// Table rows and hand sequences push expected results to a scoreboard queue when driven;
// results are popped and compared one time unit after the following rising edge.
module tb_pc_sequencer;

  localparam logic [7:0] BR  = 8'h01;
  localparam logic [7:0] BNZ = 8'h02;
  localparam logic [7:0] Z   = 8'h04;
  localparam logic [7:0] UB  = 8'h08;
  localparam logic [7:0] RB  = 8'h10;
  localparam logic [7:0] LK  = 8'h20;
  localparam logic [7:0] RT  = 8'h40;
  localparam logic [7:0] ST  = 8'h80;

  typedef struct {
    string       name;
    logic [7:0]  ctrl;
    logic [63:0] imm;
    logic [63:0] tgt;
    logic [63:0] exp_next;
    logic [63:0] exp_pc;
    logic        exp_empty;
    logic        exp_full;
    logic        exp_ovf;
  } rec_t;

  logic CLK;
  logic resetl;
  int   errors = 0;
  int   checks = 0;
  rec_t sb_q[$];
  rec_t tbl[$];

  pc_sequencer_if #(.XLEN(64)) bus ();

  pc_sequencer #(
    .XLEN     (64),
    .RESET_PC (64'h0),
    .RAS_DEPTH(4),
    .IMM_SHIFT(2)
  ) dut (
    .CLK   (CLK),
    .resetl(resetl),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic rec_t mk(string n, logic [7:0] c, logic [63:0] imm, logic [63:0] tgt,
                              logic [63:0] nxt, logic [63:0] pc, logic e, logic f, logic o);
    rec_t r;
    r.name = n; r.ctrl = c; r.imm = imm; r.tgt = tgt; r.exp_next = nxt; r.exp_pc = pc;
    r.exp_empty = e; r.exp_full = f; r.exp_ovf = o;
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_inputs(logic [7:0] c, logic [63:0] imm, logic [63:0] tgt);
    bus.Branch       = c[0];
    bus.BranchNZ     = c[1];
    bus.ALUZero      = c[2];
    bus.Uncondbranch = c[3];
    bus.RegBranch    = c[4];
    bus.Link         = c[5];
    bus.Return       = c[6];
    bus.stall        = c[7];
    bus.SignExtImm   = imm;
    bus.RegTarget    = tgt;
  endtask

  task automatic check_out();
    rec_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: queue empty, got 0 entries, expected 1");
      return;
    end
    e = sb_q.pop_front();
    chk({e.name, " CurrentPC"}, bus.CurrentPC, e.exp_pc);
    chk({e.name, " ras_empty"}, 64'(bus.ras_empty), 64'(e.exp_empty));
    chk({e.name, " ras_full"},  64'(bus.ras_full),  64'(e.exp_full));
    chk({e.name, " ras_ovf"},   64'(bus.ras_ovf),   64'(e.exp_ovf));
  endtask

  // Called at posedge+1: drive, check NextPC combinationally, then check state after the edge.
  task automatic drive(rec_t r);
    set_inputs(r.ctrl, r.imm, r.tgt);
    sb_q.push_back(r);
    #1;
    chk({r.name, " NextPC"}, bus.NextPC, r.exp_next);
    @(posedge CLK);
    #1;
    check_out();
  endtask

  initial begin
    logic [63:0] m_pc;
    logic [63:0] m_ras[$];
    logic        m_ovf;
    logic [63:0] link;

    resetl = 1'b0;
    set_inputs(8'h00, 64'h0, 64'h0);
    #3;
    chk("reset CurrentPC", bus.CurrentPC, 64'h0);
    chk("reset NextPC", bus.NextPC, 64'h4);
    chk("reset LinkAddr", bus.LinkAddr, 64'h4);
    chk("reset ras_empty", 64'(bus.ras_empty), 64'h1);
    chk("reset ras_full", 64'(bus.ras_full), 64'h0);
    chk("reset ras_ovf", 64'(bus.ras_ovf), 64'h0);
    repeat (2) @(posedge CLK);
    #1;
    resetl = 1'b1;

    //                 name        ctrl            imm              tgt       next      pc      e  f  o
    tbl.push_back(mk("seq1",      8'h00,          64'h0,           64'h0,    64'h4,    64'h4,   1, 0, 0));
    tbl.push_back(mk("seq2",      8'h00,          64'h0,           64'h0,    64'h8,    64'h8,   1, 0, 0));
    tbl.push_back(mk("seq3",      8'h00,          64'h0,           64'h0,    64'hC,    64'hC,   1, 0, 0));
    tbl.push_back(mk("br100",     RB,             64'h0,           64'h100,  64'h100,  64'h100, 1, 0, 0));
    tbl.push_back(mk("cbz_tk",    BR|Z,           64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'hF0, 64'hF0, 1, 0, 0));
    tbl.push_back(mk("br100b",    RB,             64'h0,           64'h100,  64'h100,  64'h100, 1, 0, 0));
    tbl.push_back(mk("cbnz_nt",   BR|BNZ|Z,       64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h104, 64'h104, 1, 0, 0));
    tbl.push_back(mk("cbnz_tk",   BR|BNZ,         64'h4,           64'h0,    64'h114,  64'h114, 1, 0, 0));
    tbl.push_back(mk("cbz_nt",    BR,             64'h4,           64'h0,    64'h118,  64'h118, 1, 0, 0));
    tbl.push_back(mk("br200",     RB,             64'h0,           64'h200,  64'h200,  64'h200, 1, 0, 0));
    tbl.push_back(mk("bl",        UB|LK,          64'h10,          64'h0,    64'h240,  64'h240, 0, 0, 0));
    tbl.push_back(mk("ret",       RT,             64'h0,           64'h0,    64'h204,  64'h204, 1, 0, 0));
    tbl.push_back(mk("link_only", LK,             64'h0,           64'h0,    64'h208,  64'h208, 0, 0, 0));
    tbl.push_back(mk("link_ret",  LK|RT,          64'h0,           64'h0,    64'h208,  64'h208, 0, 0, 0));
    tbl.push_back(mk("ret_swap",  RT,             64'h0,           64'h0,    64'h20C,  64'h20C, 1, 0, 0));
    tbl.push_back(mk("ret_empty", RT,             64'h0,           64'h555,  64'h555,  64'h555, 1, 0, 0));
    tbl.push_back(mk("lr_empty",  LK|RT,          64'h0,           64'h700,  64'h700,  64'h700, 0, 0, 0));
    tbl.push_back(mk("ret_lre",   RT,             64'h0,           64'h0,    64'h559,  64'h559, 1, 0, 0));
    tbl.push_back(mk("prio_rb",   RB|UB|BR|Z,     64'h1,           64'h1003, 64'h1000, 64'h1000, 1, 0, 0));
    tbl.push_back(mk("link2",     LK,             64'h0,           64'h0,    64'h1004, 64'h1004, 0, 0, 0));
    tbl.push_back(mk("prio_ret",  RT|RB|UB,       64'h5,           64'h9003, 64'h1004, 64'h1004, 1, 0, 0));
    tbl.push_back(mk("prio_ub",   UB|BR,          64'h2,           64'h0,    64'h100C, 64'h100C, 1, 0, 0));
    for (int i = 0; i < tbl.size(); i++) drive(tbl[i]);

    // Overflow: five BL pushes into a 4-deep stack, then five returns.
    m_pc  = 64'h100C;
    m_ovf = 1'b0;
    for (int i = 0; i < 5; i++) begin
      link = m_pc + 64'd4;
      if (m_ras.size() == 4) begin
        void'(m_ras.pop_front());
        m_ovf = 1'b1;
      end
      m_ras.push_back(link);
      m_pc = m_pc + 64'd16;
      drive(mk($sformatf("bl_ovf%0d", i), UB|LK, 64'h4, 64'h0, m_pc, m_pc,
               1'b0, m_ras.size() == 4, m_ovf));
    end
    for (int i = 0; i < 5; i++) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else m_pc = 64'h3000;
      drive(mk($sformatf("ret_ovf%0d", i), RT, 64'h0, 64'h3000, m_pc, m_pc,
               m_ras.size() == 0, m_ras.size() == 4, m_ovf));
    end

    // Stall with a taken branch and Link asserted: nothing may move.
    drive(mk("br400", RB, 64'h0, 64'h400, 64'h400, 64'h400, 1, 0, 1));
    drive(mk("push404", LK, 64'h0, 64'h0, 64'h404, 64'h404, 0, 0, 1));
    for (int i = 0; i < 3; i++)
      drive(mk($sformatf("stall%0d", i), ST|BR|Z|LK, 64'h8, 64'h0, 64'h424, 64'h404, 0, 0, 1));
    drive(mk("ret_stall", RT, 64'h0, 64'h0, 64'h404, 64'h404, 1, 0, 1));
    drive(mk("ret_after", RT, 64'h0, 64'h888, 64'h888, 64'h888, 1, 0, 1));

    // Reset pulse in the middle of a stall.
    drive(mk("push88c", LK, 64'h0, 64'h0, 64'h88C, 64'h88C, 0, 0, 1));
    set_inputs(ST|UB, 64'h4, 64'h0);
    #2;
    resetl = 1'b0;
    #1;
    chk("midrst CurrentPC", bus.CurrentPC, 64'h0);
    chk("midrst NextPC", bus.NextPC, 64'h10);
    chk("midrst ras_empty", 64'(bus.ras_empty), 64'h1);
    chk("midrst ras_ovf", 64'(bus.ras_ovf), 64'h0);
    @(posedge CLK);
    #1;
    chk("inrst CurrentPC", bus.CurrentPC, 64'h0);
    resetl = 1'b1;
    @(posedge CLK);
    #1;
    chk("poststall CurrentPC", bus.CurrentPC, 64'h0);
    drive(mk("rst_adv", 8'h00, 64'h0, 64'h0, 64'h4, 64'h4, 1, 0, 0));

    // Modulo wrap-around.
    drive(mk("to_top", RB, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC,
             64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0));
    chk("wrap LinkAddr", bus.LinkAddr, 64'h0);
    drive(mk("wrap", 8'h00, 64'h0, 64'h0, 64'h0, 64'h0, 1, 0, 0));
    drive(mk("wrap_back", UB, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC,
             64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0));
    drive(mk("br1003", RB, 64'h0, 64'h1003, 64'h1000, 64'h1000, 1, 0, 0));

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d entries left, expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
